// File: rtl/core_pkg.sv
// Shared core parameters plus the operand-fetch slot type and a write-hit helper.
package core_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREG   = 32;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned OP_W   = 6;

  // Instruction fields held in the operand-fetch slot.
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [IDX_W-1:0] rd;
    logic             rd_we;
    logic             use_a;
    logic             use_b;
  } slot_t;

  // True when an enabled write targets idx.
  function automatic logic idx_hit(input logic en, input logic [IDX_W-1:0] widx,
                                   input logic [IDX_W-1:0] idx);
    return en && (widx == idx);
  endfunction

endpackage

// File: rtl/scoreboard.sv
// Outstanding-write scoreboard: one bit per register, two clear ports and one set port.
// A set and a clear of the same index in the same cycle leave the bit set.
module scoreboard
  import core_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic             clr_wb_en,
  input  logic [IDX_W-1:0] clr_wb_idx,
  input  logic             clr_fl_en,
  input  logic [IDX_W-1:0] clr_fl_idx,
  output logic [NREG-1:0]  pending
);

  logic [NREG-1:0] pending_q, pending_d;

  // Next state: apply clears first so the set is the last word.
  always_comb begin
    pending_d = pending_q;
    if (clr_wb_en) pending_d[clr_wb_idx] = 1'b0;
    if (clr_fl_en) pending_d[clr_fl_idx] = 1'b0;
    if (set_en)    pending_d[set_idx]    = 1'b1;
  end

  // Scoreboard state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: hazard check against the scoreboard, register-file read issue,
// one holding slot towards execute.
// Build option: OPERAND_FETCH_BYPASS_EN enables same-cycle writeback bypass, which
// clears the RAW hazard in the writeback cycle and forwards the written data.
module operand_fetch
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [IDX_W-1:0]  in_rs_a,
  input  logic [IDX_W-1:0]  in_rs_b,
  input  logic              in_use_a,
  input  logic              in_use_b,
  input  logic [IDX_W-1:0]  in_rd,
  input  logic              in_rd_we,
  output logic              rf_r_en_a,
  output logic              rf_r_en_b,
  output logic [IDX_W-1:0]  rf_r_idx_a,
  output logic [IDX_W-1:0]  rf_r_idx_b,
  input  logic [DATA_W-1:0] rf_r_data_a,
  input  logic [DATA_W-1:0] rf_r_data_b,
  input  logic              wb_en,
  input  logic [IDX_W-1:0]  wb_idx,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_op,
  output logic [IDX_W-1:0]  out_rd,
  output logic              out_rd_we,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [NREG-1:0]   pending
);

  logic  pend_a, pend_b;
  logic  hz_a, hz_b, hz_d;
  logic  accept;
  logic  s1_valid_q, s1_valid_d;
  slot_t s1_q;

`ifdef OPERAND_FETCH_BYPASS_EN
  logic              fwd_a_q, fwd_b_q;
  logic [DATA_W-1:0] fwd_a_data_q, fwd_b_data_q;
`else
  // wb_data only feeds the forward path, which this build does not have.
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
`endif

  // Hazard detection, handshake and register-file read issue.
  always_comb begin
`ifdef OPERAND_FETCH_BYPASS_EN
    pend_a = pending[in_rs_a] & ~idx_hit(wb_en, wb_idx, in_rs_a);
    pend_b = pending[in_rs_b] & ~idx_hit(wb_en, wb_idx, in_rs_b);
`else
    pend_a = pending[in_rs_a];
    pend_b = pending[in_rs_b];
`endif
    hz_a      = in_use_a & pend_a;
    hz_b      = in_use_b & pend_b;
    // A retiring write to the same rd frees the slot in the scoreboard this cycle.
    hz_d      = in_rd_we & pending[in_rd] & ~idx_hit(wb_en, wb_idx, in_rd);
    in_ready  = (~s1_valid_q | out_ready) & ~hz_a & ~hz_b & ~hz_d & ~flush;
    accept    = in_valid & in_ready;
    rf_r_en_a = accept & in_use_a;
    rf_r_en_b = accept & in_use_b;
  end

  assign rf_r_idx_a = in_rs_a;
  assign rf_r_idx_b = in_rs_b;

  // Slot occupancy: flush beats accept, accept beats drain.
  always_comb begin
    s1_valid_d = s1_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (accept) begin
      s1_valid_d = 1'b1;
    end else if (out_ready) begin
      s1_valid_d = 1'b0;
    end
  end

  // Slot register: capture decoded fields on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_q.op    <= in_op;
        s1_q.rd    <= in_rd;
        s1_q.rd_we <= in_rd_we;
        s1_q.use_a <= in_use_a;
        s1_q.use_b <= in_use_b;
      end
    end
  end

`ifdef OPERAND_FETCH_BYPASS_EN
  // Forward capture: the register file returns the pre-write value on a same-edge
  // read/write, so the writeback data is latched here instead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_a_q      <= 1'b0;
      fwd_b_q      <= 1'b0;
      fwd_a_data_q <= '0;
      fwd_b_data_q <= '0;
    end else if (accept) begin
      fwd_a_q      <= idx_hit(wb_en, wb_idx, in_rs_a);
      fwd_b_q      <= idx_hit(wb_en, wb_idx, in_rs_b);
      fwd_a_data_q <= wb_data;
      fwd_b_data_q <= wb_data;
    end
  end
`endif

  // Operand select for the held instruction.
  always_comb begin
`ifdef OPERAND_FETCH_BYPASS_EN
    out_a = ~s1_q.use_a ? '0 : (fwd_a_q ? fwd_a_data_q : rf_r_data_a);
    out_b = ~s1_q.use_b ? '0 : (fwd_b_q ? fwd_b_data_q : rf_r_data_b);
`else
    out_a = s1_q.use_a ? rf_r_data_a : '0;
    out_b = s1_q.use_b ? rf_r_data_b : '0;
`endif
  end

  assign out_valid = s1_valid_q;
  assign out_op    = s1_q.op;
  assign out_rd    = s1_q.rd;
  assign out_rd_we = s1_q.rd_we;

  scoreboard u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .set_en     (accept & in_rd_we),
    .set_idx    (in_rd),
    .clr_wb_en  (wb_en),
    .clr_wb_idx (wb_idx),
    .clr_fl_en  (flush & s1_valid_q & s1_q.rd_we),
    .clr_fl_idx (s1_q.rd),
    .pending    (pending)
  );

endmodule

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch: directed scenarios followed by randomized traffic, all
// checked every cycle against a behavioural model (register values, pending set, slot
// contents) kept here. Honours OPERAND_FETCH_BYPASS_EN like the design.
`timescale 1ns/1ps
module tb_operand_fetch;
  import core_pkg::*;

`ifdef OPERAND_FETCH_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready;
  logic [OP_W-1:0]   in_op;
  logic [IDX_W-1:0]  in_rs_a, in_rs_b, in_rd;
  logic              in_use_a, in_use_b, in_rd_we;
  logic              rf_r_en_a, rf_r_en_b;
  logic [IDX_W-1:0]  rf_r_idx_a, rf_r_idx_b;
  logic [DATA_W-1:0] rf_r_data_a = '0, rf_r_data_b = '0;
  logic              wb_en;
  logic [IDX_W-1:0]  wb_idx;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic              out_valid, out_ready;
  logic [OP_W-1:0]   out_op;
  logic [IDX_W-1:0]  out_rd;
  logic              out_rd_we;
  logic [DATA_W-1:0] out_a, out_b;
  logic [NREG-1:0]   pending;

  operand_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_rs_a     (in_rs_a),
    .in_rs_b     (in_rs_b),
    .in_use_a    (in_use_a),
    .in_use_b    (in_use_b),
    .in_rd       (in_rd),
    .in_rd_we    (in_rd_we),
    .rf_r_en_a   (rf_r_en_a),
    .rf_r_en_b   (rf_r_en_b),
    .rf_r_idx_a  (rf_r_idx_a),
    .rf_r_idx_b  (rf_r_idx_b),
    .rf_r_data_a (rf_r_data_a),
    .rf_r_data_b (rf_r_data_b),
    .wb_en       (wb_en),
    .wb_idx      (wb_idx),
    .wb_data     (wb_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op      (out_op),
    .out_rd      (out_rd),
    .out_rd_we   (out_rd_we),
    .out_a       (out_a),
    .out_b       (out_b),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  // Register file: registered read, pre-write value on a same-edge read/write.
  logic [DATA_W-1:0] rf_mem [NREG];
  always @(posedge clk) begin
    if (rf_r_en_a) rf_r_data_a <= rf_mem[rf_r_idx_a];
    if (rf_r_en_b) rf_r_data_b <= rf_mem[rf_r_idx_b];
    if (wb_en)     rf_mem[wb_idx] <= wb_data;
  end

  // Behavioural model state.
  typedef struct {
    bit                valid;
    logic [OP_W-1:0]   op;
    logic [IDX_W-1:0]  rd;
    bit                rd_we;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } exp_slot_t;

  exp_slot_t m_slot;
  bit        m_pend [NREG];
  int        exec_q [$];   // destinations handed to execute, awaiting writeback
  int        n_checks = 0;
  int        n_errors = 0;
  int        n_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [IDX_W-1:0] idx);
    return wb_en && (wb_idx == idx);
  endfunction

  function automatic logic [NREG-1:0] pend_vec();
    logic [NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // Value an accepted source must present in execute.
  function automatic logic [DATA_W-1:0] src_val(input logic [IDX_W-1:0] idx, input bit use_it);
    if (!use_it) return '0;
    if (Byp && hit(idx)) return wb_data;
    return rf_mem[idx];
  endfunction

  // Compare process: check outputs mid-cycle, then advance the model over the next edge.
  always @(negedge clk) begin
    bit ready, acc, deliver, blocked;
    if (reset) begin
      chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset_pending", pending, 32'd0);
      m_slot.valid = 1'b0;
      for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
      exec_q.delete();
    end else begin
      blocked = (in_use_a && m_pend[in_rs_a] && !(Byp && hit(in_rs_a))) ||
                (in_use_b && m_pend[in_rs_b] && !(Byp && hit(in_rs_b))) ||
                (in_rd_we && m_pend[in_rd] && !hit(in_rd));
      ready   = (!m_slot.valid || out_ready) && !blocked && !flush;
      acc     = in_valid && ready;
      deliver = m_slot.valid && out_ready && !flush;

      chk("in_ready", {31'b0, in_ready}, {31'b0, ready});
      chk("rf_r_en_a", {31'b0, rf_r_en_a}, {31'b0, acc && in_use_a});
      chk("rf_r_en_b", {31'b0, rf_r_en_b}, {31'b0, acc && in_use_b});
      chk("rf_r_idx_a", {27'b0, rf_r_idx_a}, {27'b0, in_rs_a});
      chk("rf_r_idx_b", {27'b0, rf_r_idx_b}, {27'b0, in_rs_b});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_slot.valid});
      chk("pending", pending, pend_vec());
      if (m_slot.valid) begin
        chk("out_op", {26'b0, out_op}, {26'b0, m_slot.op});
        chk("out_rd", {27'b0, out_rd}, {27'b0, m_slot.rd});
        chk("out_rd_we", {31'b0, out_rd_we}, {31'b0, m_slot.rd_we});
        chk("out_a", {16'b0, out_a}, {16'b0, m_slot.a});
        chk("out_b", {16'b0, out_b}, {16'b0, m_slot.b});
      end

      if (deliver && m_slot.rd_we) exec_q.push_back(int'(m_slot.rd));
      if (wb_en) m_pend[wb_idx] = 1'b0;
      if (flush && m_slot.valid && m_slot.rd_we) m_pend[m_slot.rd] = 1'b0;
      if (acc && in_rd_we) m_pend[in_rd] = 1'b1;

      if (flush) begin
        m_slot.valid = 1'b0;
      end else if (acc) begin
        m_slot.valid = 1'b1;
        m_slot.op    = in_op;
        m_slot.rd    = in_rd;
        m_slot.rd_we = in_rd_we;
        m_slot.a     = src_val(in_rs_a, in_use_a);
        m_slot.b     = src_val(in_rs_b, in_use_b);
      end else if (deliver) begin
        m_slot.valid = 1'b0;
      end
      if (acc) n_acc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 0; in_op = '0; in_rs_a = '0; in_rs_b = '0;
    in_use_a = 0; in_use_b = 0; in_rd = '0; in_rd_we = 0;
  endtask

  task automatic send(input logic [OP_W-1:0] op, input int ra, input bit ua,
                      input int rb, input bit ub, input int rd, input bit we);
    in_valid = 1; in_op = op;
    in_rs_a = IDX_W'(ra); in_use_a = ua;
    in_rs_b = IDX_W'(rb); in_use_b = ub;
    in_rd = IDX_W'(rd); in_rd_we = we;
  endtask

  task automatic do_wb(input int idx, input logic [DATA_W-1:0] data);
    wb_en = 1; wb_idx = IDX_W'(idx); wb_data = data;
    for (int i = 0; i < exec_q.size(); i++) begin
      if (exec_q[i] == idx) begin
        exec_q.delete(i);
        break;
      end
    end
  endtask

  task automatic no_wb();
    wb_en = 0; wb_idx = '0; wb_data = '0;
  endtask

  initial begin
    int a0;
    reset = 1; flush = 0; out_ready = 0;
    idle_in();
    no_wb();
    for (int i = 0; i < NREG; i++) rf_mem[i] = DATA_W'($urandom);
    rf_mem[3] = 16'h1234;
    rf_mem[4] = 16'h00FF;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_pending", pending, 32'd0);
    chk("rst_out_a", {16'b0, out_a}, 32'd0);
    chk("rst_out_b", {16'b0, out_b}, 32'd0);
    chk("rst_out_op", {26'b0, out_op}, 32'd0);
    chk("rst_out_rd_we", {31'b0, out_rd_we}, 32'd0);
    chk("rst_rf_r_en_a", {31'b0, rf_r_en_a}, 32'd0);
    reset = 0;

    // Independent op: r3/r4 read, rd=5 becomes pending.
    out_ready = 1;
    send(6'h2A, 3, 1, 4, 1, 5, 1);
    #1;
    chk("ind_in_ready", {31'b0, in_ready}, 32'd1);
    chk("ind_rf_en_a", {31'b0, rf_r_en_a}, 32'd1);
    tick();
    idle_in();
    chk("ind_out_valid", {31'b0, out_valid}, 32'd1);
    chk("ind_out_a", {16'b0, out_a}, 32'h1234);
    chk("ind_out_b", {16'b0, out_b}, 32'h00FF);
    chk("ind_out_op", {26'b0, out_op}, 32'h2A);
    chk("ind_pend5", {31'b0, pending[5]}, 32'd1);

    // RAW on r5, resolved by writeback 0xBEEF.
    send(6'h11, 5, 1, 0, 0, 6, 1);
    #1;
    chk("raw_stall0", {31'b0, in_ready}, 32'd0);
    tick();
    chk("raw_stall1", {31'b0, in_ready}, 32'd0);
    tick();
    chk("raw_stall2", {31'b0, in_ready}, 32'd0);
    do_wb(5, 16'hBEEF);
    #1;
`ifdef OPERAND_FETCH_BYPASS_EN
    chk("raw_wb_ready", {31'b0, in_ready}, 32'd1);
    tick();
    idle_in();
    no_wb();
`else
    chk("raw_wb_ready", {31'b0, in_ready}, 32'd0);
    tick();
    no_wb();
    #1;
    chk("raw_after_ready", {31'b0, in_ready}, 32'd1);
    tick();
    idle_in();
`endif
    chk("raw_out_valid", {31'b0, out_valid}, 32'd1);
    chk("raw_out_a", {16'b0, out_a}, 32'hBEEF);

    // Backpressure with an unrelated writeback to r7 during the hold.
    out_ready = 0;
    send(6'h22, 1, 1, 2, 1, 8, 1);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) do_wb(7, 16'h7777);
      else no_wb();
      #1;
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_rf_en_a", {31'b0, rf_r_en_a}, 32'd0);
      chk("bp_rf_en_b", {31'b0, rf_r_en_b}, 32'd0);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_out_a", {16'b0, out_a}, 32'hBEEF);
      tick();
    end
    no_wb();
    out_ready = 1;
    #1;
    chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
    tick();
    idle_in();
    chk("bp_next_op", {26'b0, out_op}, 32'h22);

    // WAW on r9 with a same-cycle writeback: accepted, bit stays set.
    send(6'h05, 0, 0, 0, 0, 9, 1);
    tick();
    idle_in();
    tick();
    chk("waw_pend9_before", {31'b0, pending[9]}, 32'd1);
    send(6'h06, 0, 0, 0, 0, 9, 1);
    do_wb(9, 16'h0909);
    #1;
    chk("waw_ready", {31'b0, in_ready}, 32'd1);
    tick();
    idle_in();
    no_wb();
    chk("waw_pend9_after", {31'b0, pending[9]}, 32'd1);
    chk("waw_out_op", {26'b0, out_op}, 32'h06);

    // Flush of a held rd=12 with a simultaneous handshake and a waiting op.
    send(6'h0C, 0, 0, 0, 0, 12, 1);
    tick();
    idle_in();
    out_ready = 0;
    tick();
    chk("fl_pend12_held", {31'b0, pending[12]}, 32'd1);
    flush = 1;
    out_ready = 1;
    send(6'h0D, 1, 1, 0, 0, 13, 1);
    #1;
    chk("fl_in_ready", {31'b0, in_ready}, 32'd0);
    chk("fl_rf_en_a", {31'b0, rf_r_en_a}, 32'd0);
    tick();
    flush = 0;
    idle_in();
    chk("fl_out_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_pend12", {31'b0, pending[12]}, 32'd0);
    chk("fl_pend13", {31'b0, pending[13]}, 32'd0);

    // Drain outstanding writes, then build pending = r5|r10 with the slot held.
    for (int i = 0; i < 64 && exec_q.size() > 0; i++) begin
      do_wb(exec_q[0], DATA_W'($urandom));
      tick();
    end
    no_wb();
    tick();
    chk("drain_pending", pending, 32'd0);
    send(6'h15, 0, 0, 0, 0, 5, 1);
    tick();
    send(6'h1A, 0, 0, 0, 0, 10, 1);
    tick();
    idle_in();
    out_ready = 0;
    chk("mr_pending", pending, 32'h0000_0420);
    chk("mr_out_valid", {31'b0, out_valid}, 32'd1);

    // Mid-operation reset.
    reset = 1;
    #1;
    chk("mr_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mr_rst_pending", pending, 32'd0);
    tick();
    chk("mr_rst_hold_valid", {31'b0, out_valid}, 32'd0);
    reset = 0;
    #1;
    chk("mr_release_ready", {31'b0, in_ready}, 32'd1);
    tick();

    // Randomized traffic.
    a0 = n_acc;
    for (int c = 0; c < 3000; c++) begin
      int hi;
      hi = ($urandom_range(0, 3) == 0) ? NREG - 1 : 7;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = OP_W'($urandom);
      in_rs_a   = IDX_W'($urandom_range(0, hi));
      in_rs_b   = IDX_W'($urandom_range(0, hi));
      in_use_a  = $urandom_range(0, 1) == 1;
      in_use_b  = $urandom_range(0, 1) == 1;
      in_rd     = IDX_W'($urandom_range(0, hi));
      in_rd_we  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      if (exec_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        do_wb(exec_q[$urandom_range(0, exec_q.size() - 1)], DATA_W'($urandom));
      end else begin
        no_wb();
      end
      tick();
    end
    idle_in();
    no_wb();
    flush = 0;
    out_ready = 1;
    chk("random_accepts_min", {31'b0, (n_acc - a0) > 200}, 32'd1);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
